// File: rtl/asteroid_scheduler.sv
// Asteroid spawn scheduler.
// Decides when a new asteroid enters the playfield, which of three slots it
// occupies and at which column it appears. Difficulty rises every LEVEL_FRAMES
// frames by shortening the gap between spawns, down to a floor of MIN_GAP.
//
// Ports
//   clk          pixel clock, single domain
//   reset        asynchronous, active-high
//   start        level-sensitive game-start request
//   halt         collision flag; freezes the game
//   frame_tick   one-cycle pulse per video frame
//   random[4:0]  free-running random value
//   slot_done    per-slot pulse: asteroid left the screen
//   asteroid_on  per-slot active flag
//   spawn_pulse  one-cycle load strobe for the selected slot
//   spawn_x      spawn column (random*20), held between spawns
//   level        difficulty level, saturating at 15
//   state        IDLE=00, RUN=01, HALTED=10
module asteroid_scheduler #(
  parameter int SPAWN_GAP    = 60,
  parameter int MIN_GAP      = 20,
  parameter int GAP_STEP     = 4,
  parameter int LEVEL_FRAMES = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       halt,
  input  logic       frame_tick,
  input  logic [4:0] random,
  input  logic [2:0] slot_done,
  output logic [2:0] asteroid_on,
  output logic [2:0] spawn_pulse,
  output logic [9:0] spawn_x,
  output logic [3:0] level,
  output logic [1:0] state
);

  localparam int unsigned GW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
  localparam int unsigned LW = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;

  localparam logic [GW-1:0] GAP_INIT  = GW'(SPAWN_GAP);
  localparam logic [GW-1:0] GAP_FLOOR = GW'(MIN_GAP);
  localparam logic [GW-1:0] GAP_DEC   = GW'(GAP_STEP);
  localparam logic [GW:0]   GAP_LIMIT = (GW + 1)'(MIN_GAP + GAP_STEP);
  localparam logic [LW-1:0] LVL_LAST  = LW'(LEVEL_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HALTED = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    asteroid_on_q, asteroid_on_d;
  logic [2:0]    spawn_pulse_q, spawn_pulse_d;
  logic [9:0]    spawn_x_q, spawn_x_d;
  logic [3:0]    level_q, level_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [GW-1:0] cur_gap_q, cur_gap_d;
  logic [LW-1:0] lvl_cnt_q, lvl_cnt_d;

  logic [2:0]    free_slots;
  logic [2:0]    pick;
  logic          spawn_now;

  // Free slots come from the registered flags, so a slot released by
  // slot_done this cycle only becomes eligible on the following cycle.
  assign free_slots = ~asteroid_on_q;
  // Isolate the lowest set bit: lowest-index free slot as a one-hot.
  assign pick       = free_slots & (~free_slots + 3'd1);

  always_comb begin
    state_d       = state_q;
    asteroid_on_d = asteroid_on_q;
    spawn_pulse_d = '0;
    spawn_x_d     = spawn_x_q;
    level_d       = level_q;
    gap_cnt_d     = gap_cnt_q;
    cur_gap_d     = cur_gap_q;
    lvl_cnt_d     = lvl_cnt_q;
    spawn_now     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !halt) state_d = S_RUN;
      end

      S_RUN: begin
        if (halt) begin
          // Halt wins over any pending spawn; everything freezes.
          state_d = S_HALTED;
        end else begin
          // >= rather than == keeps the spawn reachable when a level-up
          // shrinks cur_gap below an already saturated gap_cnt.
          spawn_now     = (gap_cnt_q >= cur_gap_q) && (free_slots != '0);
          asteroid_on_d = asteroid_on_q & ~slot_done;

          if (spawn_now) begin
            asteroid_on_d = asteroid_on_d | pick;
            spawn_pulse_d = pick;
            spawn_x_d     = {1'b0, random, 4'b0000} + {3'b000, random, 2'b00};
            gap_cnt_d     = '0;
          end else if (frame_tick && (gap_cnt_q < cur_gap_q)) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end

          // Level-up only updates cur_gap_d; this cycle's spawn test above
          // already used the old cur_gap_q.
          if (frame_tick) begin
            if (lvl_cnt_q == LVL_LAST) begin
              lvl_cnt_d = '0;
              if (level_q != 4'hF) level_d = level_q + 4'd1;
              if ({1'b0, cur_gap_q} >= GAP_LIMIT) cur_gap_d = cur_gap_q - GAP_DEC;
              else                                cur_gap_d = GAP_FLOOR;
            end else begin
              lvl_cnt_d = lvl_cnt_q + LW'(1);
            end
          end
        end
      end

      S_HALTED: begin
        if (start && !halt) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Any cycle that lands in IDLE starts the next game from scratch.
    if (state_d == S_IDLE) begin
      asteroid_on_d = '0;
      gap_cnt_d     = '0;
      lvl_cnt_d     = '0;
      level_d       = '0;
      cur_gap_d     = GAP_INIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      asteroid_on_q <= '0;
      spawn_pulse_q <= '0;
      spawn_x_q     <= '0;
      level_q       <= '0;
      gap_cnt_q     <= '0;
      cur_gap_q     <= GAP_INIT;
      lvl_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      asteroid_on_q <= asteroid_on_d;
      spawn_pulse_q <= spawn_pulse_d;
      spawn_x_q     <= spawn_x_d;
      level_q       <= level_d;
      gap_cnt_q     <= gap_cnt_d;
      cur_gap_q     <= cur_gap_d;
      lvl_cnt_q     <= lvl_cnt_d;
    end
  end

  assign asteroid_on = asteroid_on_q;
  assign spawn_pulse = spawn_pulse_q;
  assign spawn_x     = spawn_x_q;
  assign level       = level_q;
  assign state       = state_q;

endmodule

// File: tb/tb_asteroid_scheduler.sv
module tb_asteroid_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       frame_tick = 1'b0;
  logic [4:0] random = '0;
  logic [2:0] slot_done = '0;
  logic [2:0] asteroid_on;
  logic [2:0] spawn_pulse;
  logic [9:0] spawn_x;
  logic [3:0] level;
  logic [1:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned spawn_cnt = 0;
  int unsigned multi_cnt = 0;

  asteroid_scheduler #(
    .SPAWN_GAP(4),
    .MIN_GAP(2),
    .GAP_STEP(1),
    .LEVEL_FRAMES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .halt(halt),
    .frame_tick(frame_tick),
    .random(random),
    .slot_done(slot_done),
    .asteroid_on(asteroid_on),
    .spawn_pulse(spawn_pulse),
    .spawn_x(spawn_x),
    .level(level),
    .state(state)
  );

  always #5 clk = ~clk;

  // Spawn-pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (spawn_pulse != 3'b000) spawn_cnt++;
    if ($countones(spawn_pulse) > 1) multi_cnt++;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: tick edge, possible spawn edge, settle edge.
  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
  endtask

  // Tick edge then the edge where a spawn pulse would appear.
  task automatic tick_then_spawn_edge();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  int unsigned exp_cnt [16] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3};

  initial begin
    #1 reset = 1'b1;
    #2;
    check("rst_state", state, 0);
    check("rst_on", asteroid_on, 0);
    check("rst_pulse", spawn_pulse, 0);
    check("rst_x", spawn_x, 0);
    check("rst_level", level, 0);
    step();
    reset = 1'b0;
    frame();
    frame();
    check("idle_hold_state", state, 0);
    check("idle_hold_cnt", spawn_cnt, 0);

    // First spawn after 4 frame ticks.
    random = 5'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    check("run_state", state, 1);
    for (int i = 0; i < 3; i++) frame();
    check("no_early_spawn", spawn_cnt, 0);
    tick_then_spawn_edge();
    check("spawn0_pulse", spawn_pulse, 1);
    check("spawn0_x", spawn_x, 140);
    check("spawn0_on", asteroid_on, 1);
    step();
    check("spawn0_one_cycle", spawn_pulse, 0);

    // Ticks 5..16: spawns at ticks 8 and 11 (gap 3 after level-up at 10).
    for (int t = 5; t <= 16; t++) begin
      frame();
      check($sformatf("cnt_tick%0d", t), spawn_cnt, exp_cnt[t-1]);
    end
    check("full_on", asteroid_on, 7);
    check("level_after16", level, 1);

    // Free slot 1 with all slots full and gap saturated: respawn without a tick.
    slot_done = 3'b010;
    step();
    slot_done = 3'b000;
    check("done_clears", asteroid_on, 5);
    check("done_no_same_cycle", spawn_pulse, 0);
    step();
    check("respawn_pulse", spawn_pulse, 2);
    check("respawn_on", asteroid_on, 7);
    step();
    check("respawn_cnt", spawn_cnt, 4);

    // Ticks 17..30: level 2 at tick 20, level 3 at tick 30.
    for (int t = 17; t <= 30; t++) begin
      frame();
      if (t == 20) check("level_at20", level, 2);
    end
    check("level_at30", level, 3);

    // Free slot 0, then slot 2 on the edge slot 0 is refilled.
    slot_done = 3'b001;
    step();
    slot_done = 3'b100;
    step();
    slot_done = 3'b000;
    check("refill0_pulse", spawn_pulse, 1);
    check("refill0_on", asteroid_on, 3);
    step();
    // Floor gap of 2: one tick is not enough, two are.
    frame();
    check("floor_gap_wait", spawn_cnt, 5);
    tick_then_spawn_edge();
    check("floor_gap_pulse", spawn_pulse, 4);
    step();
    check("floor_gap_cnt", spawn_cnt, 6);

    // Halt on the cycle the spawn condition is true.
    frame();
    frame();
    slot_done = 3'b001;
    step();
    slot_done = 3'b000;
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_state", state, 2);
    check("halt_no_pulse", spawn_pulse, 0);
    check("halt_on", asteroid_on, 6);
    random = 5'd3;
    for (int i = 0; i < 5; i++) frame();
    slot_done = 3'b010;
    step();
    slot_done = 3'b000;
    step();
    check("halted_state", state, 2);
    check("halted_level", level, 3);
    check("halted_on", asteroid_on, 6);
    check("halted_x", spawn_x, 140);
    check("halted_cnt", spawn_cnt, 6);
    start = 1'b1;
    step();
    check("back_idle_state", state, 0);
    check("back_idle_on", asteroid_on, 0);
    check("back_idle_level", level, 0);
    step();
    start = 1'b0;
    check("restart_state", state, 1);

    // Restart: gap must be back to 4.
    for (int i = 0; i < 3; i++) frame();
    check("restart_no_early", spawn_cnt, 6);
    tick_then_spawn_edge();
    check("restart_pulse", spawn_pulse, 1);
    check("restart_x", spawn_x, 60);
    step();
    for (int i = 0; i < 4; i++) frame();
    check("restart_on011", asteroid_on, 3);
    check("restart_cnt", spawn_cnt, 8);

    // Ticks 9,10 (level-up to gap 3), tick 11 spawns slot 2; reset mid-pulse.
    frame();
    frame();
    check("restart_level", level, 1);
    tick_then_spawn_edge();
    check("pre_reset_pulse", spawn_pulse, 4);
    #1 reset = 1'b1;
    #1;
    check("async_state", state, 0);
    check("async_pulse", spawn_pulse, 0);
    check("async_on", asteroid_on, 0);
    check("async_x", spawn_x, 0);
    check("async_level", level, 0);
    #1 reset = 1'b0;
    step();
    for (int i = 0; i < 6; i++) frame();
    check("post_reset_idle", state, 0);
    check("post_reset_on", asteroid_on, 0);
    check("post_reset_cnt", spawn_cnt, 8);
    check("onehot_pulses", multi_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
